// File: rtl/note_peak_scanner.sv
//==============================================================================
// Module   : note_peak_scanner
// Purpose  : Time-shared peak picker over the 88 DFT key bins (one bin/cycle).
//            Optional result hold filter enabled by defining NOTE_HOLD_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module note_peak_scanner
`ifdef NOTE_HOLD_EN
#(
  parameter int HOLD_FRAMES = 3
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [26:0] threshold,
  output logic        rd_en,
  output logic [6:0]  rd_addr,
  input  logic [26:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic [6:0]  note,
  output logic [26:0] peak
);

  localparam logic [6:0] C_LAST_BIN = 7'd88;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [6:0]  r_addr;
  logic [26:0] r_thresh;
  logic [26:0] r_max;
  logic [6:0]  r_idx;
  logic        r_cmp_valid;
  logic [6:0]  r_cmp_idx;

  logic        w_accept;
  logic        w_take;
  logic [26:0] w_max;
  logic [6:0]  w_idx;
  logic        w_hit;
  logic [6:0]  w_cand_note;
  logic [26:0] w_cand_peak;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = READ;
      READ:    if (r_addr == C_LAST_BIN) w_state_next = DRAIN;
      DRAIN:   w_state_next = DONE;
      DONE:    w_state_next = start ? READ : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign rd_en    = (r_state == READ);
  assign rd_addr  = rd_en ? r_addr : 7'd0;
  assign busy     = (r_state == READ) || (r_state == DRAIN);
  assign done     = (r_state == DONE);
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  // Compare stage trails the reads by one cycle; strict '>' keeps the lower index on ties.
  assign w_take      = r_cmp_valid && (rd_data > r_max);
  assign w_max       = w_take ? rd_data : r_max;
  assign w_idx       = w_take ? r_cmp_idx : r_idx;
  assign w_hit       = (w_max > r_thresh);
  assign w_cand_note = w_hit ? w_idx : 7'd0;
  assign w_cand_peak = w_hit ? w_max : 27'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= 7'd0;
      r_thresh    <= 27'd0;
      r_max       <= 27'd0;
      r_idx       <= 7'd0;
      r_cmp_valid <= 1'b0;
      r_cmp_idx   <= 7'd0;
    end else begin
      r_cmp_valid <= rd_en;
      r_cmp_idx   <= r_addr;
      if (w_accept) begin
        r_thresh <= threshold;
        r_max    <= 27'd0;
        r_idx    <= 7'd0;
        r_addr   <= 7'd1;
      end else begin
        if (r_state == READ) r_addr <= r_addr + 7'd1;
        r_max <= w_max;
        r_idx <= w_idx;
      end
    end
  end

  // Result registers load on the DRAIN->DONE edge so they change together with done.
`ifdef NOTE_HOLD_EN
  logic [3:0] r_hold_cnt;
  logic [6:0] r_prev_note;
  logic [3:0] w_cnt_next;

  always_comb begin
    w_cnt_next = 4'd1;
    if ((r_hold_cnt != 4'd0) && (w_cand_note == r_prev_note))
      w_cnt_next = (r_hold_cnt == 4'd15) ? 4'd15 : r_hold_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt  <= 4'd0;
      r_prev_note <= 7'd0;
      note        <= 7'd0;
      peak        <= 27'd0;
    end else if (r_state == DRAIN) begin
      r_hold_cnt  <= w_cnt_next;
      r_prev_note <= w_cand_note;
      if (int'(w_cnt_next) >= HOLD_FRAMES) begin
        note <= w_cand_note;
        peak <= w_cand_peak;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note <= 7'd0;
      peak <= 27'd0;
    end else if (r_state == DRAIN) begin
      note <= w_cand_note;
      peak <= w_cand_peak;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_note_peak_scanner.sv
//==============================================================================
// Module   : tb_note_peak_scanner
// Purpose  : Directed self-checking bench for note_peak_scanner.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_note_peak_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [26:0] threshold = 27'd0;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [26:0] rd_data = 27'd0;
  logic        busy;
  logic        done;
  logic [6:0]  note;
  logic [26:0] peak;

  logic [26:0] mem [1:88];
  int tests = 0;
  int failed = 0;

  note_peak_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .threshold (threshold),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .note      (note),
    .peak      (peak)
  );

  always #5 clk = ~clk;

  // Bin RAM model: one-cycle read latency, junk on idle cycles.
  always @(posedge clk) begin
    if (rd_en && rd_addr >= 7'd1 && rd_addr <= 7'd88) rd_data <= mem[rd_addr];
    else rd_data <= 27'h5A5A5A5;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [26:0] v);
    for (int i = 1; i <= 88; i++) mem[i] = v;
  endtask

  // Starts a scan and returns the cycle count until done (cycle 1 = first read).
  task automatic do_scan(input logic [26:0] thr, input bit perturb,
                         output int lat, output bit addr_ok);
    threshold = thr;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    addr_ok = 1'b1;
    while (!done && lat < 200) begin
      if (lat <= 88) begin
        if (!rd_en || rd_addr != lat[6:0]) addr_ok = 1'b0;
      end else if (rd_en || rd_addr != 7'd0) addr_ok = 1'b0;
      if (perturb && lat == 30) threshold = 27'h7FFFFFF;
      if (perturb && lat == 40) start = 1'b1;
      if (perturb && lat == 41) start = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string name, input int lat, input bit addr_ok,
                              input logic [6:0] exp_note, input logic [26:0] exp_peak);
    tests++;
    if (lat !== 90) begin
      failed++;
      $display("FAIL %s latency: got %0d expected 90", name, lat);
    end
    tests++;
    if (addr_ok !== 1'b1) begin
      failed++;
      $display("FAIL %s rd_addr sequence: got bad expected 1..88", name);
    end
    tests++;
    if (note !== exp_note) begin
      failed++;
      $display("FAIL %s note: got %0d expected %0d", name, note, exp_note);
    end
    tests++;
    if (peak !== exp_peak) begin
      failed++;
      $display("FAIL %s peak: got %0h expected %0h", name, peak, exp_peak);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    tests++;
    if ({rd_en, rd_addr, busy, done, note, peak} !== 44'd0) begin
      failed++;
      $display("FAIL %s outputs: got rd_en=%b rd_addr=%0d busy=%b done=%b note=%0d peak=%0h expected all 0",
               name, rd_en, rd_addr, busy, done, note, peak);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_single_peak();
    int lat;
    bit ok;
    fill(27'd5);
    mem[40] = 27'd1000;
    do_scan(27'd100, 1'b0, lat, ok);
    check_result("single_peak", lat, ok, 7'd40, 27'd1000);
    tick();
    tests++;
    if (done !== 1'b0 || note !== 7'd40 || peak !== 27'd1000) begin
      failed++;
      $display("FAIL hold_after_done: got done=%b note=%0d peak=%0d expected 0/40/1000", done, note, peak);
    end
  endtask

  task automatic test_tie_threshold();
    int lat;
    bit ok;
    fill(27'd0);
    mem[10] = 27'd500;
    mem[70] = 27'd500;
    do_scan(27'd499, 1'b0, lat, ok);
    check_result("tie_low_index", lat, ok, 7'd10, 27'd500);
    tick();
    do_scan(27'd500, 1'b0, lat, ok);
    check_result("threshold_equal", lat, ok, 7'd0, 27'd0);
    tick();
  endtask

  task automatic test_boundary();
    int lat;
    bit ok;
    fill(27'd0);
    mem[88] = 27'h7FFFFFF;
    do_scan(27'd0, 1'b0, lat, ok);
    check_result("bin88_max", lat, ok, 7'd88, 27'h7FFFFFF);
    tick();
    fill(27'd0);
    mem[1] = 27'd1;
    do_scan(27'd0, 1'b0, lat, ok);
    check_result("bin1_one", lat, ok, 7'd1, 27'd1);
    tick();
    fill(27'd0);
    do_scan(27'd0, 1'b0, lat, ok);
    check_result("all_zero", lat, ok, 7'd0, 27'd0);
    tick();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int first = 0;
    int second = 0;
    int guard = 0;
    int lat;
    bit ok;
    fill(27'd5);
    mem[40] = 27'd1000;
    threshold = 27'd100;
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (done) begin
        n++;
        if (n == 1) first = c;
        if (n == 2) second = c;
      end
    end
    start = 1'b0;
    tests++;
    if (n !== 2 || first !== 90 || second !== 180) begin
      failed++;
      $display("FAIL back_to_back: got %0d dones at %0d,%0d expected 2 at 90,180", n, first, second);
    end
    while ((busy || done) && guard < 200) begin
      tick();
      guard++;
    end
    tests++;
    if (guard >= 200) begin
      failed++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", guard);
    end
    // Mid-scan threshold change and start pulse must both be ignored.
    do_scan(27'd100, 1'b1, lat, ok);
    check_result("perturbed_scan", lat, ok, 7'd40, 27'd1000);
    tick();
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL dropped_start: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    fill(27'd5);
    mem[40] = 27'd1000;
    threshold = 27'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 45; c++) tick();
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_scan");
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("after_reset_release");
    mem[40] = 27'd5;
    mem[63] = 27'd777;
    do_scan(27'd100, 1'b0, lat, ok);
    check_result("scan_after_reset", lat, ok, 7'd63, 27'd777);
    tick();
  endtask

`ifdef NOTE_HOLD_EN
  task automatic test_hold();
    int lat;
    bit ok;
    logic [6:0] exp_notes [5];
    logic [6:0] seq [5];
    seq = '{7'd40, 7'd40, 7'd52, 7'd52, 7'd52};
    exp_notes = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd52};
    for (int s = 0; s < 5; s++) begin
      fill(27'd5);
      mem[seq[s]] = 27'd900;
      do_scan(27'd100, 1'b0, lat, ok);
      tests++;
      if (lat !== 90 || note !== exp_notes[s]) begin
        failed++;
        $display("FAIL hold_scan%0d: got lat=%0d note=%0d expected 90/%0d", s, lat, note, exp_notes[s]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    fill(27'd0);
    test_reset();
`ifdef NOTE_HOLD_EN
    test_hold();
`else
    test_single_peak();
    test_tie_threshold();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
